// File: rtl/uart_tx_fifo_wrapper.sv
// Memory-mapped UART transmitter: TX FIFO, serial engine, sticky status, irq.
module uart_tx_fifo_wrapper #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       read,
  input  logic       write,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       tx,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count;
  logic [4:0]           ctrl;
  logic                 ovf, done;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        nxt_bit;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l, par_odd_l, stop2_l;

  logic full, empty, push_req, push, pop, w1c;
  logic baud_last, stop_last, done_set;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_req  = write && (addr == 3'd0);
  // A full FIFO refuses the push even if the engine pops in the same cycle.
  assign push      = push_req && !full;
  assign pop       = (state == IDLE) && ctrl[0] && !empty;
  assign w1c       = write && (addr == 3'd2);
  assign baud_last = (baud == CW'(CLKS_PER_BIT - 1));
  assign stop_last = !stop2_l || (bit_cnt == BW'(1));
  assign done_set  = (state == STOP) && baud_last && stop_last && empty;
  assign nxt_bit   = bit_cnt + 1'b1;
  assign ready     = ~full;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in[DATA_BITS-1:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Control register, sticky flags (set beats W1C) and registered irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (write && addr == 3'd1) ctrl <= data_in[4:0];
      ovf  <= (ovf  & ~(w1c & data_in[3])) | (push_req & full);
      done <= (done & ~(w1c & data_in[4])) | done_set;
      irq  <= ctrl[4] & (ovf | done);
    end
  end

  // Serial engine; frame settings are latched at pop so CTRL edits wait a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          baud    <= '0;
          bit_cnt <= '0;
          if (pop) begin
            shreg     <= mem[rptr];
            par_en_l  <= ctrl[1];
            par_odd_l <= ctrl[2];
            stop2_l   <= ctrl[3];
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else baud <= baud + 1'b1;
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (par_en_l) begin
                tx    <= (^shreg) ^ par_odd_l;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= nxt_bit;
              tx      <= shreg[nxt_bit];
            end
          end else baud <= baud + 1'b1;
        end
        PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else baud <= baud + 1'b1;
        end
        STOP: begin
          // bit_cnt counts stop bits here
          if (baud_last) begin
            baud <= '0;
            if (stop_last) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else bit_cnt <= nxt_bit;
          end else baud <= baud + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational read mux; zero when idle or unmapped.
  always_comb begin
    data_out = 8'h00;
    if (read) begin
      case (addr)
        3'd1:    data_out = {3'b000, ctrl};
        3'd2:    data_out = {3'b000, done, ovf, (state != IDLE), full, empty};
        3'd3:    data_out = 8'(count);
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_wrapper.sv
// Scoreboard bench for uart_tx_fifo_wrapper: expected frames queued on write,
// decoded off the tx pin and compared bit by bit.
module tb_uart_tx_fifo_wrapper;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       ready, tx, irq;

  uart_tx_fifo_wrapper #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; bit pe, po, s2; } frm_t;
  frm_t exp_q[$];
  int   fall_q[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   frames_done = 0, aborted = 0;
  int   wr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [7:0] c);
    frm_t f;
    f.d = d; f.pe = c[1]; f.po = c[2]; f.s2 = c[3];
    exp_q.push_back(f);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); write = 1'b1; addr = a; data_in = d;
    @(negedge clk); write = 1'b0; wr_cyc = cyc;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); read = 1'b1; addr = a;
    #1 d = data_out; read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 3000) begin @(negedge clk); t++; end
    chk("frames_done", frames_done, n);
  endtask

  // One bit time: first sample at the current or next negedge, then CPB-1 more.
  task automatic samp(input bit first, output logic v, output bit stable, output bit ab);
    stable = 1'b1; ab = 1'b0;
    if (!first) @(negedge clk);
    v = tx;
    if (!rst_n) ab = 1'b1;
    for (int k = 1; k < CPB; k++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
      if (tx !== v) stable = 1'b0;
    end
  endtask

  // Frame decoder / scoreboard consumer.
  frm_t       m_e;
  logic [7:0] m_d;
  logic       m_v, m_p;
  bit         m_st, m_ab, m_ok;
  int         m_fc, m_len;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        m_fc = cyc;
        fall_q.push_back(m_fc);
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          m_d = '0; m_p = 1'b0;
          samp(1'b1, m_v, m_st, m_ab);
          m_ok = m_st && (m_v === 1'b0);
          for (int i = 0; i < 8; i++)
            if (!m_ab) begin
              samp(1'b0, m_v, m_st, m_ab);
              m_d[i] = m_v; m_ok = m_ok && m_st;
            end
          if (m_e.pe && !m_ab) begin
            samp(1'b0, m_v, m_st, m_ab);
            m_p = m_v; m_ok = m_ok && m_st;
          end
          for (int s = 0; s < (m_e.s2 ? 2 : 1); s++)
            if (!m_ab) begin
              samp(1'b0, m_v, m_st, m_ab);
              m_ok = m_ok && m_st && (m_v === 1'b1);
            end
          if (m_ab) aborted++;
          else begin
            m_len = cyc - m_fc + 1;
            chk("frame_data", m_d, m_e.d);
            if (m_e.pe) chk("frame_parity", m_p, (^m_e.d) ^ m_e.po);
            chk("frame_shape", m_ok, 1);
            chk("frame_len", m_len, CPB * (1 + 8 + (m_e.pe ? 1 : 0) + (m_e.s2 ? 2 : 1)));
            frames_done++;
          end
        end
      end
    end
  end

  int idx0;
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset and idle
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    chk("rst_ready", ready, 1);
    rd_chk("rst_status", 3'd2, 8'h01);
    rd_chk("rst_level", 3'd3, 8'h00);
    rd_chk("rst_ctrl", 3'd1, 8'h00);
    rd_chk("txdata_reads0", 3'd0, 8'h00);
    bus_wr(3'd5, 8'hFF);
    rd_chk("unmapped_rd", 3'd5, 8'h00);
    rd_chk("ctrl_after_unmapped", 3'd1, 8'h00);

    // Single frame with start latency and DONE
    bus_wr(3'd1, 8'h01);
    push_exp(8'hA5, 8'h01);
    bus_wr(3'd0, 8'hA5);
    wait_frames(1);
    chk("start_latency", fall_q[fall_q.size()-1] - wr_cyc, 1);
    rd_chk("status_done", 3'd2, 8'h11);

    // Parity odd, two stops; then parity even
    bus_wr(3'd1, 8'h0F);
    push_exp(8'h03, 8'h0F);
    bus_wr(3'd0, 8'h03);
    wait_frames(2);
    bus_wr(3'd1, 8'h0B);
    push_exp(8'h03, 8'h0B);
    bus_wr(3'd0, 8'h03);
    wait_frames(3);

    // FIFO full and overflow
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd2, 8'h18);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_exp(8'h10 + 8'(i), 8'h01);
      bus_wr(3'd0, 8'h10 + 8'(i));
    end
    rd_chk("full_level", 3'd3, 8'h08);
    chk("full_ready", ready, 0);
    rd_chk("full_status", 3'd2, 8'h0A);
    bus_wr(3'd2, 8'h08);
    rd_chk("ovf_cleared", 3'd2, 8'h02);
    idx0 = fall_q.size();
    bus_wr(3'd1, 8'h01);
    wait_frames(11);
    for (int i = 0; i < 7; i++)
      chk("b2b_gap", fall_q[idx0+i+1] - fall_q[idx0+i], 41);
    rd_chk("drain_status", 3'd2, 8'h11);

    // Interrupt and W1C
    bus_wr(3'd1, 8'h11);
    @(negedge clk);
    chk("irq_set", irq, 1);
    bus_wr(3'd2, 8'h10);
    @(negedge clk);
    chk("irq_clr", irq, 0);
    rd_chk("done_clr", 3'd2, 8'h01);
    push_exp(8'h81, 8'h11);
    bus_wr(3'd0, 8'h81);
    repeat (40) @(negedge clk);
    write = 1'b1; addr = 3'd2; data_in = 8'h10;
    @(negedge clk);
    write = 1'b0;
    wait_frames(12);
    rd_chk("set_beats_clr", 3'd2, 8'h11);
    @(negedge clk);
    chk("irq_after_race", irq, 1);

    // Mid-frame CTRL change and EN clear
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd2, 8'h18);
    bus_wr(3'd0, 8'h5A);
    bus_wr(3'd0, 8'h3C);
    rd_chk("mid_level2", 3'd3, 8'h02);
    push_exp(8'h5A, 8'h01);
    bus_wr(3'd1, 8'h01);
    repeat (12) @(negedge clk);
    bus_wr(3'd1, 8'h08);
    rd_chk("mid_level1", 3'd3, 8'h01);
    wait_frames(13);
    repeat (10) @(negedge clk);
    rd_chk("mid_level_hold", 3'd3, 8'h01);
    rd_chk("mid_status", 3'd2, 8'h00);

    // Reset in the middle of a frame
    push_exp(8'h3C, 8'h01);
    bus_wr(3'd1, 8'h01);
    repeat (10) @(negedge clk);
    chk("pre_rst_tx_low_or_data", frames_done, 13);
    #1 rst_n = 1'b0;
    #1 chk("rst_tx_immediate", tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_level", 3'd3, 8'h00);
    rd_chk("post_rst_status", 3'd2, 8'h01);
    repeat (60) @(negedge clk);
    chk("post_rst_idle_tx", tx, 1);
    chk("aborted", aborted, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_wrapper.md
Name: uart_tx_fifo_wrapper

Overview:
- Memory-mapped UART transmitter with an integrated serial engine and a transmit FIFO.
- Parametrised in baud divisor, data width and FIFO depth; runtime-selectable parity and stop-bit count; sticky status and an interrupt output.
- Sits on the same 3-bit-address peripheral bus as the other UART wrappers and drives the serial TX pin directly.

Parameters:
- CLKS_PER_BIT, 87: clock cycles per serial bit; legal values are 2 and above.
- DATA_BITS, 8: data bits per frame; legal range 5..8; data_in[DATA_BITS-1:0] is used.
- FIFO_DEPTH, 8: TX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read  in  1  bus read strobe.
- write  in  1  bus write strobe; one write per cycle.
- addr  in  3  register address.
- data_in  in  8  write data.
- data_out  out  8  read data; combinational, valid in the cycle read=1; 8'h00 when read=0 or the address is unmapped.
- ready  out  1  high when the FIFO is not full (~full).
- tx  out  1  serial output, LSB first; idle level is 1.
- irq  out  1  level interrupt.

Behaviour:
- Registers:
  - addr 0, TXDATA (write-only): pushes data_in into the FIFO. If the FIFO is full, the push is dropped and OVF is set. Reads return 0.
  - addr 1, CTRL (read/write, reset 0x00): bit0 EN, bit1 PAR_EN, bit2 PAR_ODD, bit3 STOP2, bit4 IRQ_EN. Bits 7:5 read 0.
  - addr 2, STATUS: bit0 EMPTY, bit1 FULL, bit2 BUSY (engine not IDLE), bit3 OVF (sticky), bit4 DONE (sticky).
    - Writing 1 to bit3 or bit4 clears that bit (write-1-to-clear). Other bits are read-only.
  - addr 3, LEVEL: FIFO count, 0..FIFO_DEPTH, zero-extended.
  - Addresses 4..7 are unmapped: writes ignored, reads return 0.
- Reset values: tx=1, irq=0, ready=1, FIFO empty, CTRL=0, OVF=0, DONE=0, engine in IDLE. Reset asserted mid-frame forces tx=1 immediately and discards the FIFO and the frame in progress.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - A push is accepted only if not full, even when a pop occurs in the same cycle.
  - Simultaneous accepted push and pop leaves the count unchanged.
  - The count updates on the edge that samples the write.
- Engine FSM: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
  - IDLE: tx=1. If EN=1 and the FIFO is non-empty, pop the head, latch the byte plus PAR_EN/PAR_ODD/STOP2, set tx<=0, go to START.
  - A baud counter runs 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first; a bit counter selects the current bit.
  - PARITY: even parity is the XOR of the data bits; odd parity is its inverse.
  - STOP: tx=1 for 1 bit time (STOP2=0) or 2 bit times (STOP2=1).
  - At the end of STOP, return to IDLE. If the FIFO is then empty, set DONE.
  - Back-to-back frames have exactly one idle clock cycle between the last stop cycle and the next start bit.
- Latency: when the FIFO is empty and the engine idle with EN=1, tx falls on the first edge after the edge that samples the TXDATA write.
- CTRL changes mid-frame do not affect the current frame; they apply at the next pop. Clearing EN mid-frame lets the current frame finish, and no further pops occur.
- Sticky clear versus set in the same cycle: the set wins.
- irq = IRQ_EN & (OVF | DONE), registered. It updates one cycle after the flags change.

Test Plan:
- Reset and idle (CLKS_PER_BIT=4): release rst_n -> tx=1, irq=0, ready=1, STATUS=0x01, LEVEL=0; CTRL reads 0x00.
- Single frame: CTRL=0x01, write 0xA5 -> tx falls one cycle after the write edge. Bits are 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles. Frame length is 40 cycles, DONE=1 at frame end.
- Parity and stop: CTRL=0x0F, write 0x03 -> parity bit 1 (odd), 8 stop cycles, frame length 48; repeat with CTRL=0x0B -> parity bit 0.
- FIFO full and overflow: EN=0, write 9 bytes with FIFO_DEPTH=8 -> LEVEL=8, ready=0, OVF=1, 9th byte lost. Set EN=1 -> 8 frames with 1-cycle gaps, bytes in write order.
- Interrupt and W1C: IRQ_EN=1, frame completes -> irq=1. Write 0x10 to addr 2 -> DONE=0 and irq=0 next cycle. A clear coinciding with a new DONE set leaves DONE=1.
- Mid-frame events: change CTRL.STOP2 and clear EN during the DATA state -> current frame unchanged, FIFO count holds. Pulse rst_n low mid-frame -> tx=1 immediately, LEVEL=0.
